// File: rtl/top_memoryaccess_pkg.sv
// Shared decode constants and types for the memory-access stage.
package top_memoryaccess_pkg;

    // Decoded-op layout: bit0 = load, bit1 = store, bits[4:2] = funct3.
    localparam int OPLEN_DEFAULT = 8;
    localparam int MEM_LOAD_BIT  = 0;
    localparam int MEM_STORE_BIT = 1;
    localparam int FUNCT3_BIT_L  = 2;
    localparam int FUNCT3_BIT_M  = 4;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Access size lives in funct3[1:0] for both loads and stores.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/top_memoryaccess_load_align.sv
// Selects the addressed byte/halfword of a load word and extends it.
module load_align
    import top_memoryaccess_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata[8*gi +: 8];
    end

    // Pick the lane and apply sign or zero extension by load kind.
    always_comb begin
        byte_sel = lane[byte_off];
        half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            FUNCT3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
            FUNCT3_LH:  data = {{16{half_sel[15]}}, half_sel};
            FUNCT3_LBU: data = {24'h0, byte_sel};
            FUNCT3_LHU: data = {16'h0, half_sel};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/top_memoryaccess.sv
// Memory-access pipeline stage: issues data-memory requests, waits for ack,
// aligns load data and latches writeback values.
module top_memoryaccess
    import top_memoryaccess_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OPLEN = OPLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               phase_memoryaccess,
    input  logic [OPLEN-1:0]   decoded_op_em,
    input  logic [XLEN-1:0]    rs2data_em,
    input  logic [XLEN-1:0]    alu_out_em,
    input  logic [XLEN-1:0]    next_pc_em,
    input  logic               jump_state_em,
    input  logic [4:0]         rdsel_em,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic [XLEN/8-1:0]  dmem_be,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic [XLEN-1:0]    rd_data_mw,
    output logic [XLEN-1:0]    next_pc_mw,
    output logic [4:0]         rdsel_mw,
    output logic               jump_state_mw,
    output logic [OPLEN-1:0]   decoded_op_mw,
    output logic               misalign_mw,
    output logic               stall_memoryaccess
);

    localparam int BE_W    = XLEN / 8;
    localparam int LATCH_W = XLEN + XLEN + 5 + 1 + OPLEN + 1;

    state_t state_reg, state_next;

    logic              is_load, is_store, misalign_em, mem_go;
    logic [2:0]        funct3_em;
    logic [XLEN-1:0]   wdata_next;
    logic [BE_W-1:0]   be_next;
    logic              issue, latch_en, latch_from_mem;

    // Request context captured at WAIT entry so the *_em inputs may change.
    logic [OPLEN-1:0]  cap_op_reg;
    logic [XLEN-1:0]   cap_addr_reg;
    logic [XLEN-1:0]   cap_next_pc_reg;
    logic              cap_jump_reg;
    logic [4:0]        cap_rdsel_reg;
    logic [XLEN-1:0]   load_data;

    logic [LATCH_W-1:0] out_reg, out_next;

    assign is_load     = decoded_op_em[MEM_LOAD_BIT];
    assign is_store    = decoded_op_em[MEM_STORE_BIT];
    assign funct3_em   = decoded_op_em[FUNCT3_BIT_M:FUNCT3_BIT_L];
    assign misalign_em = (is_load | is_store) & is_misaligned(funct3_em[1:0], alu_out_em[1:0]);
    assign mem_go      = (is_load | is_store) & ~misalign_em;

    // Store lane formatting; loads read the full word.
    always_comb begin
        wdata_next = rs2data_em;
        be_next    = '1;
        if (is_store) begin
            case (funct3_em[1:0])
                2'b00: begin
                    wdata_next = {4{rs2data_em[7:0]}};
                    be_next    = BE_W'(1) << alu_out_em[1:0];
                end
                2'b01: begin
                    wdata_next = {2{rs2data_em[15:0]}};
                    be_next    = alu_out_em[1] ? BE_W'(4'b1100) : BE_W'(4'b0011);
                end
                default: begin
                    wdata_next = rs2data_em;
                    be_next    = '1;
                end
            endcase
        end
    end

    load_align u_load_align (
        .funct3   (cap_op_reg[FUNCT3_BIT_M:FUNCT3_BIT_L]),
        .byte_off (cap_addr_reg[1:0]),
        .rdata    (dmem_rdata),
        .data     (load_data)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Next state, stall and latch/issue strobes.
    always_comb begin
        state_next         = state_reg;
        stall_memoryaccess = 1'b0;
        issue              = 1'b0;
        latch_en           = 1'b0;
        latch_from_mem     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (phase_memoryaccess) begin
                    if (mem_go) begin
                        state_next         = ST_WAIT;
                        stall_memoryaccess = 1'b1;
                        issue              = 1'b1;
                    end else begin
                        latch_en = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                stall_memoryaccess = ~dmem_ack;
                if (dmem_ack) begin
                    state_next     = ST_IDLE;
                    latch_en       = 1'b1;
                    latch_from_mem = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (rst) stall_memoryaccess = 1'b0;
    end

    // Writeback latch contents: captured context on ack, live inputs otherwise.
    always_comb begin
        if (latch_from_mem)
            out_next = {cap_op_reg[MEM_LOAD_BIT] ? load_data : cap_addr_reg,
                        cap_next_pc_reg, cap_rdsel_reg, cap_jump_reg, cap_op_reg, 1'b0};
        else
            out_next = {alu_out_em, next_pc_em, rdsel_em, jump_state_em,
                        decoded_op_em, misalign_em};
    end

    // Request registers, capture registers and the writeback latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= '0;
            dmem_wdata      <= '0;
            dmem_be         <= '0;
            cap_op_reg      <= '0;
            cap_addr_reg    <= '0;
            cap_next_pc_reg <= '0;
            cap_jump_reg    <= 1'b0;
            cap_rdsel_reg   <= '0;
            out_reg         <= '0;
        end else begin
            if (latch_en) out_reg <= out_next;
            if (issue) begin
                dmem_req        <= 1'b1;
                dmem_we         <= is_store;
                dmem_addr       <= {alu_out_em[XLEN-1:2], 2'b00};
                dmem_wdata      <= wdata_next;
                dmem_be         <= be_next;
                cap_op_reg      <= decoded_op_em;
                cap_addr_reg    <= alu_out_em;
                cap_next_pc_reg <= next_pc_em;
                cap_jump_reg    <= jump_state_em;
                cap_rdsel_reg   <= rdsel_em;
            end else if (latch_from_mem) begin
                dmem_req <= 1'b0;
                dmem_we  <= 1'b0;
            end
        end
    end

    assign {rd_data_mw, next_pc_mw, rdsel_mw, jump_state_mw, decoded_op_mw, misalign_mw} = out_reg;

endmodule

// File: tb/tb_top_memoryaccess.sv
// Scoreboard bench: stimulus pushes expected writeback values, a monitor
// pops and compares on every completed phase (phase=1 and stall=0).
module tb_top_memoryaccess;
    import top_memoryaccess_pkg::*;

    localparam int XLEN  = 32;
    localparam int OPLEN = OPLEN_DEFAULT;

    logic              clk = 1'b0;
    logic              rst;
    logic              phase_memoryaccess;
    logic [OPLEN-1:0]  decoded_op_em;
    logic [XLEN-1:0]   rs2data_em, alu_out_em, next_pc_em;
    logic              jump_state_em;
    logic [4:0]        rdsel_em;
    logic              dmem_req, dmem_we;
    logic [XLEN-1:0]   dmem_addr, dmem_wdata;
    logic [XLEN/8-1:0] dmem_be;
    logic              dmem_ack;
    logic [XLEN-1:0]   dmem_rdata;
    logic [XLEN-1:0]   rd_data_mw, next_pc_mw;
    logic [4:0]        rdsel_mw;
    logic              jump_state_mw;
    logic [OPLEN-1:0]  decoded_op_mw;
    logic              misalign_mw;
    logic              stall_memoryaccess;

    top_memoryaccess #(.XLEN(XLEN), .OPLEN(OPLEN)) dut (
        .clk(clk), .rst(rst), .phase_memoryaccess(phase_memoryaccess),
        .decoded_op_em(decoded_op_em), .rs2data_em(rs2data_em),
        .alu_out_em(alu_out_em), .next_pc_em(next_pc_em),
        .jump_state_em(jump_state_em), .rdsel_em(rdsel_em),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .rd_data_mw(rd_data_mw), .next_pc_mw(next_pc_mw),
        .rdsel_mw(rdsel_mw), .jump_state_mw(jump_state_mw),
        .decoded_op_mw(decoded_op_mw), .misalign_mw(misalign_mw),
        .stall_memoryaccess(stall_memoryaccess)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [OPLEN-1:0] op;
        logic [31:0]      alu;
        logic [31:0]      rs2;
        logic [31:0]      npc;
        logic             jump;
        logic [4:0]       rdsel;
        int               ack_delay;
        logic [31:0]      rdata;
        logic [31:0]      exp_rd;
        logic             exp_mis;
        logic             exp_req;
        logic [31:0]      exp_addr;
        logic             exp_we;
        logic [31:0]      exp_wdata;
        logic [3:0]       exp_be;
        int               exp_stalls;
    } vec_t;

    typedef struct {
        string            name;
        logic [31:0]      rd;
        logic [31:0]      npc;
        logic [4:0]       rdsel;
        logic             jump;
        logic [OPLEN-1:0] op;
        logic             mis;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [OPLEN-1:0] mk_op(input logic ld, input logic st, input logic [2:0] f3);
        return {3'b010, f3, st, ld};
    endfunction

    // Monitor: a completed phase is phase=1 with stall=0 at a rising edge.
    always @(posedge clk) begin : monitor
        exp_t e;
        if (!rst && phase_memoryaccess && !stall_memoryaccess) begin
            #1;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got unexpected completion, required none");
            end else begin
                e = sb_q.pop_front();
                chk({e.name, ".rd_data"},  rd_data_mw,    e.rd);
                chk({e.name, ".next_pc"},  next_pc_mw,    e.npc);
                chk({e.name, ".rdsel"},    32'(rdsel_mw), 32'(e.rdsel));
                chk({e.name, ".jump"},     32'(jump_state_mw), 32'(e.jump));
                chk({e.name, ".op"},       32'(decoded_op_mw), 32'(e.op));
                chk({e.name, ".misalign"}, 32'(misalign_mw), 32'(e.mis));
                $display("txn %-8s rd=0x%08h npc=0x%08h rdsel=%0d mis=%0b",
                         e.name, rd_data_mw, next_pc_mw, rdsel_mw, misalign_mw);
            end
        end
    end

    task automatic run_op(input vec_t v);
        int   stalls;
        int   waits;
        exp_t e;
        stalls = 0;
        waits  = 0;
        @(negedge clk);
        decoded_op_em      = v.op;
        alu_out_em         = v.alu;
        rs2data_em         = v.rs2;
        next_pc_em         = v.npc;
        jump_state_em      = v.jump;
        rdsel_em           = v.rdsel;
        phase_memoryaccess = 1'b1;
        e = '{v.name, v.exp_rd, v.npc, v.rdsel, v.jump, v.op, v.exp_mis};
        sb_q.push_back(e);
        #1;
        while (stall_memoryaccess && waits < 20) begin
            stalls++;
            @(negedge clk);
            chk({v.name, ".req_held"}, 32'(dmem_req), 32'(v.exp_req));
            if (waits == 0) begin
                chk({v.name, ".addr"}, dmem_addr, v.exp_addr);
                chk({v.name, ".we"},   32'(dmem_we), 32'(v.exp_we));
                chk({v.name, ".be"},   32'(dmem_be), 32'(v.exp_be));
                if (v.exp_we) chk({v.name, ".wdata"}, dmem_wdata, v.exp_wdata);
            end
            // Inputs wander during WAIT; the captured context must be used.
            decoded_op_em = 8'hA0;
            alu_out_em    = 32'hDEAD_BEEF;
            rs2data_em    = 32'h0;
            next_pc_em    = 32'h0;
            jump_state_em = ~v.jump;
            rdsel_em      = 5'd31;
            if (waits == v.ack_delay) begin
                dmem_ack   = 1'b1;
                dmem_rdata = v.rdata;
            end
            waits++;
            #1;
        end
        if (waits >= 20) begin
            checks++;
            errors++;
            $display("FAIL %s.timeout: got stall after %0d cycles, required ack completion", v.name, waits);
        end
        @(posedge clk);
        @(negedge clk);
        phase_memoryaccess = 1'b0;
        dmem_ack           = 1'b0;
        chk({v.name, ".stall_cycles"}, 32'(stalls), 32'(v.exp_stalls));
        chk({v.name, ".req_after"},    32'(dmem_req), 32'h0);
    endtask

    vec_t vecs[$];

    initial begin
        rst                = 1'b1;
        phase_memoryaccess = 1'b1;
        decoded_op_em      = mk_op(1'b1, 1'b0, FUNCT3_LW);
        alu_out_em         = 32'h100;
        rs2data_em         = 32'h0;
        next_pc_em         = 32'h4;
        jump_state_em      = 1'b0;
        rdsel_em           = 5'd1;
        dmem_ack           = 1'b0;
        dmem_rdata         = 32'h0;

        // Reset state, with an aligned load presented: stall must stay low.
        @(negedge clk);
        @(negedge clk);
        chk("rst.stall",    32'(stall_memoryaccess), 32'h0);
        chk("rst.req",      32'(dmem_req), 32'h0);
        chk("rst.rd_data",  rd_data_mw, 32'h0);
        chk("rst.misalign", 32'(misalign_mw), 32'h0);
        phase_memoryaccess = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        //            name     op                              alu          rs2          npc       j     rd  ack rdata         exp_rd        mis  req  addr       we   wdata         be    stalls
        vecs.push_back('{"alu",   8'hA0,                        32'h1234,    32'h55,      32'h1004, 1'b0, 5,  0, 32'h0,        32'h1234,     1'b0,1'b0,32'h0,     1'b0,32'h0,        4'h0, 0});
        vecs.push_back('{"lb",    mk_op(1,0,FUNCT3_LB),         32'h103,     32'h0,       32'h1008, 1'b1, 7,  3, 32'h80FF_FF7F,32'hFFFF_FF80,1'b0,1'b1,32'h100,   1'b0,32'h0,        4'hF, 4});
        vecs.push_back('{"lhu",   mk_op(1,0,FUNCT3_LHU),        32'h102,     32'h0,       32'h100C, 1'b0, 8,  0, 32'h8001_1234,32'h0000_8001,1'b0,1'b1,32'h100,   1'b0,32'h0,        4'hF, 1});
        vecs.push_back('{"sb",    mk_op(0,1,FUNCT3_SB),         32'h201,     32'hAB,      32'h1010, 1'b0, 0,  2, 32'hFFFF_FFFF,32'h201,      1'b0,1'b1,32'h200,   1'b1,32'hABAB_ABAB,4'h2, 3});
        vecs.push_back('{"sw_mis",mk_op(0,1,FUNCT3_SW),         32'h202,     32'h11,      32'h1014, 1'b0, 0,  0, 32'h0,        32'h202,      1'b1,1'b0,32'h0,     1'b0,32'h0,        4'h0, 0});
        vecs.push_back('{"lh",    mk_op(1,0,FUNCT3_LH),         32'h100,     32'h0,       32'h1018, 1'b0, 9,  1, 32'h0000_F00D,32'hFFFF_F00D,1'b0,1'b1,32'h100,   1'b0,32'h0,        4'hF, 2});
        vecs.push_back('{"lw",    mk_op(1,0,FUNCT3_LW),         32'h104,     32'h0,       32'h101C, 1'b1, 10, 0, 32'h1234_5678,32'h1234_5678,1'b0,1'b1,32'h104,   1'b0,32'h0,        4'hF, 1});
        vecs.push_back('{"lbu",   mk_op(1,0,FUNCT3_LBU),        32'h101,     32'h0,       32'h1020, 1'b0, 11, 0, 32'h0000_9A00,32'h0000_009A,1'b0,1'b1,32'h100,   1'b0,32'h0,        4'hF, 1});
        vecs.push_back('{"sh",    mk_op(0,1,FUNCT3_SH),         32'h302,     32'h1234_BEEF,32'h1024,1'b0, 0,  0, 32'h0,        32'h302,      1'b0,1'b1,32'h300,   1'b1,32'hBEEF_BEEF,4'hC, 1});
        vecs.push_back('{"sw",    mk_op(0,1,FUNCT3_SW),         32'h40C,     32'hCAFE_F00D,32'h1028,1'b1, 0,  1, 32'h0,        32'h40C,      1'b0,1'b1,32'h40C,   1'b1,32'hCAFE_F00D,4'hF, 2});
        vecs.push_back('{"lh_mis",mk_op(1,0,FUNCT3_LH),         32'h101,     32'h0,       32'h102C, 1'b0, 12, 0, 32'h0,        32'h101,      1'b1,1'b0,32'h0,     1'b0,32'h0,        4'h0, 0});

        foreach (vecs[i]) run_op(vecs[i]);

        // With phase low in IDLE the latch holds despite new inputs.
        @(negedge clk);
        decoded_op_em = 8'hA0;
        alu_out_em    = 32'h9999;
        repeat (2) @(negedge clk);
        chk("hold.rd_data",  rd_data_mw, 32'h101);
        chk("hold.misalign", 32'(misalign_mw), 32'h1);
        chk("hold.stall",    32'(stall_memoryaccess), 32'h0);

        // Reset while waiting on a load, then a late ack.
        decoded_op_em      = mk_op(1'b1, 1'b0, FUNCT3_LW);
        alu_out_em         = 32'h500;
        phase_memoryaccess = 1'b1;
        @(negedge clk);
        chk("rstw.req_before", 32'(dmem_req), 32'h1);
        rst                = 1'b1;
        phase_memoryaccess = 1'b0;
        #1;
        chk("rstw.stall_in_rst", 32'(stall_memoryaccess), 32'h0);
        @(negedge clk);
        chk("rstw.req",     32'(dmem_req), 32'h0);
        chk("rstw.we",      32'(dmem_we), 32'h0);
        chk("rstw.addr",    dmem_addr, 32'h0);
        chk("rstw.be",      32'(dmem_be), 32'h0);
        chk("rstw.rd_data", rd_data_mw, 32'h0);
        chk("rstw.next_pc", next_pc_mw, 32'h0);
        rst        = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        repeat (2) @(negedge clk);
        chk("rstw.late_ack_req",   32'(dmem_req), 32'h0);
        chk("rstw.late_ack_rd",    rd_data_mw, 32'h0);
        chk("rstw.late_ack_stall", 32'(stall_memoryaccess), 32'h0);
        dmem_ack = 1'b0;

        // An ALU op completing with no stall proves the FSM is back in IDLE.
        run_op('{"alu_post", 8'hA0, 32'h4321, 32'h0, 32'h2000, 1'b0, 3, 0, 32'h0,
                 32'h4321, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 0});

        repeat (2) @(negedge clk);
        chk("sb.drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
